// File: rtl/led_breathe_pwm_pkg.sv
// Shared definitions for the LED breathing controller: state encoding and
// default parameter values.
package led_breathe_pwm_pkg;

  localparam int DEF_PWM_BITS   = 4;
  localparam int DEF_STEP_TICKS = 8;
  localparam int DEF_HOLD_STEPS = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    HOLD_H = 3'd2,
    DOWN   = 3'd3,
    HOLD_L = 3'd4
  } state_t;

endpackage

// File: rtl/led_breathe_pwm_pwm_gen.sv
// Free-running PWM renderer: a wrapping counter compared against the duty,
// with the compare result registered onto LED0.
module led_breathe_pwm_pwm_gen #(
  parameter int PWM_BITS = led_breathe_pwm_pkg::DEF_PWM_BITS
) (
  input  logic              CLK50,
  input  logic              RST_N,
  input  logic [PWM_BITS:0] DUTY,
  output logic              LED0
);

  logic [PWM_BITS-1:0] pwm_cnt;

  // Counter wraps naturally at MAX_DUTY-1; duty changes land mid-period.
  always_ff @(posedge CLK50) begin
    if (!RST_N) begin
      pwm_cnt <= '0;
      LED0    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      LED0    <= ({1'b0, pwm_cnt} < DUTY);
    end
  end

endmodule

// File: rtl/led_breathe_pwm.sv
// Breathing-LED controller: TICK_IN rising edges are prescaled into step
// events that ramp the PWM duty up, hold, ramp down and hold.
//
// state  | meaning
// IDLE   | effect disabled, duty forced to 0
// UP     | duty increments once per step until MAX_DUTY
// HOLD_H | duty held at MAX_DUTY for HOLD_STEPS steps
// DOWN   | duty decrements once per step until 0
// HOLD_L | duty held at 0 for HOLD_STEPS steps
module led_breathe_pwm
  import led_breathe_pwm_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int STEP_TICKS = DEF_STEP_TICKS,
  parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
  input  logic              CLK50,
  input  logic              RST_N,
  input  logic              TICK_IN,
  input  logic              EN,
  output logic              LED0,
  output logic [PWM_BITS:0] DUTY,
  output logic [2:0]        STATE,
  output logic              STEP_P
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PWM_BITS:0] MAX_DUTY = {1'b1, {PWM_BITS{1'b0}}};

  state_t            state, state_nxt;
  logic [PWM_BITS:0] duty, duty_nxt;
  logic [TW-1:0]     tick_cnt, tick_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic              tick_d, tick_edge, run, step;

  always_comb begin
    tick_edge = TICK_IN & ~tick_d;
    run       = EN && (state != IDLE);
    step      = 1'b0;
    tick_nxt  = tick_cnt;
    if (!run) begin
      tick_nxt = '0;
    end else if (tick_edge) begin
      if (tick_cnt == TW'(STEP_TICKS - 1)) begin
        tick_nxt = '0;
        step     = 1'b1;
      end else begin
        tick_nxt = tick_cnt + 1'b1;
      end
    end
  end

  // EN low overrides any step arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    hold_nxt  = hold_cnt;
    if (!EN) begin
      state_nxt = IDLE;
      duty_nxt  = '0;
      hold_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = UP;
          duty_nxt  = '0;
          hold_nxt  = '0;
        end
        UP: if (step) begin
          if (duty < MAX_DUTY) duty_nxt = duty + 1'b1;
          if (duty_nxt == MAX_DUTY) begin
            state_nxt = HOLD_H;
            hold_nxt  = '0;
          end
        end
        HOLD_H: if (step) begin
          if (hold_cnt == HW'(HOLD_STEPS - 1)) begin
            state_nxt = DOWN;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        DOWN: if (step) begin
          if (duty != '0) duty_nxt = duty - 1'b1;
          if (duty_nxt == '0) begin
            state_nxt = HOLD_L;
            hold_nxt  = '0;
          end
        end
        HOLD_L: if (step) begin
          if (hold_cnt == HW'(HOLD_STEPS - 1)) begin
            state_nxt = UP;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          duty_nxt  = '0;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // tick_d resets high so a TICK_IN held high through reset is not an edge.
  always_ff @(posedge CLK50) begin
    if (!RST_N) begin
      state    <= IDLE;
      duty     <= '0;
      tick_cnt <= '0;
      hold_cnt <= '0;
      tick_d   <= 1'b1;
      STEP_P   <= 1'b0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      tick_cnt <= tick_nxt;
      hold_cnt <= hold_nxt;
      tick_d   <= TICK_IN;
      STEP_P   <= step;
    end
  end

  assign DUTY  = duty;
  assign STATE = state;

  led_breathe_pwm_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .CLK50(CLK50),
    .RST_N(RST_N),
    .DUTY (duty),
    .LED0 (LED0)
  );

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with PWM_BITS=2, STEP_TICKS=2, HOLD_STEPS=1.
module tb_led_breathe_pwm;

  localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_HH = 3'd2, S_DN = 3'd3, S_HL = 3'd4;

  logic       CLK50 = 1'b0;
  logic       RST_N, TICK_IN, EN;
  logic       LED0, STEP_P;
  logic [2:0] DUTY;
  logic [2:0] STATE;

  int n_cmp = 0;
  int n_mis = 0;

  always #10 CLK50 = ~CLK50;

  led_breathe_pwm #(
    .PWM_BITS(2), .STEP_TICKS(2), .HOLD_STEPS(1)
  ) dut (
    .CLK50(CLK50), .RST_N(RST_N), .TICK_IN(TICK_IN), .EN(EN),
    .LED0(LED0), .DUTY(DUTY), .STATE(STATE), .STEP_P(STEP_P)
  );

  task automatic clk1();
    @(posedge CLK50);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; TICK_IN = 1'b0; EN = 1'b1;
    clk1(); clk1();
    RST_N = 1'b1;
    clk1(); clk1();
  endtask

  // One 1-cycle strobe in a 5-cycle slot; reports STEP_P at the edge and one cycle later.
  task automatic strobe(output logic sp_edge, output logic sp_after);
    TICK_IN = 1'b1; clk1(); sp_edge = STEP_P;
    TICK_IN = 1'b0; clk1(); sp_after = STEP_P;
    repeat (3) clk1();
  endtask

  task automatic count_led(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      clk1();
      if (LED0) c++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; TICK_IN = 1'b1; EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk1();
      n_cmp++; if (LED0 !== 1'b0) begin n_mis++; $display("FAIL reset_led: got %b want 0", LED0); end
      n_cmp++; if (DUTY !== 3'd0) begin n_mis++; $display("FAIL reset_duty: got %0d want 0", DUTY); end
      n_cmp++; if (STATE !== S_IDLE) begin n_mis++; $display("FAIL reset_state: got %0d want %0d", STATE, S_IDLE); end
      n_cmp++; if (STEP_P !== 1'b0) begin n_mis++; $display("FAIL reset_step_p: got %b want 0", STEP_P); end
    end
    RST_N = 1'b1;
    clk1();
    n_cmp++; if (STATE !== S_UP) begin n_mis++; $display("FAIL release_state: got %0d want %0d", STATE, S_UP); end
    clk1();
    TICK_IN = 1'b0;
    clk1(); clk1();
    n_cmp++; if (DUTY !== 3'd0) begin n_mis++; $display("FAIL release_duty: got %0d want 0", DUTY); end
  endtask

  // Continues from test_reset: UP at duty 0, tick count 0.
  task automatic test_full_ramp();
    logic [2:0] exp_st [22] = '{S_UP, S_UP, S_UP, S_UP, S_UP, S_UP, S_UP, S_HH, S_HH, S_DN, S_DN,
                                S_DN, S_DN, S_DN, S_DN, S_DN, S_DN, S_HL, S_HL, S_UP, S_UP, S_UP};
    logic [2:0] exp_du [22] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4,
                                3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic sp_e, sp_a;
    int   c;
    for (int i = 0; i < 22; i++) begin
      strobe(sp_e, sp_a);
      n_cmp++; if (STATE !== exp_st[i]) begin n_mis++; $display("FAIL ramp_state[%0d]: got %0d want %0d", i + 1, STATE, exp_st[i]); end
      n_cmp++; if (DUTY !== exp_du[i]) begin n_mis++; $display("FAIL ramp_duty[%0d]: got %0d want %0d", i + 1, DUTY, exp_du[i]); end
      n_cmp++; if (sp_e !== (i % 2 == 1)) begin n_mis++; $display("FAIL ramp_step_p[%0d]: got %b want %b", i + 1, sp_e, (i % 2 == 1)); end
      n_cmp++; if (sp_a !== 1'b0) begin n_mis++; $display("FAIL ramp_step_p_width[%0d]: got %b want 0", i + 1, sp_a); end
      if (i == 1) begin
        count_led(8, c);
        n_cmp++; if (c != 2) begin n_mis++; $display("FAIL pwm_duty1: got %0d highs want 2 of 8", c); end
      end
      if (i == 7) begin
        count_led(8, c);
        n_cmp++; if (c != 8) begin n_mis++; $display("FAIL pwm_duty4: got %0d highs want 8 of 8", c); end
      end
      if (i == 13) begin
        count_led(8, c);
        n_cmp++; if (c != 4) begin n_mis++; $display("FAIL pwm_duty2: got %0d highs want 4 of 8", c); end
      end
      if (i == 17) begin
        count_led(8, c);
        n_cmp++; if (c != 0) begin n_mis++; $display("FAIL pwm_duty0: got %0d highs want 0 of 8", c); end
      end
    end
  endtask

  task automatic test_square_wave();
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      TICK_IN = 1'b1; repeat (4) clk1();
      TICK_IN = 1'b0; repeat (4) clk1();
      n_cmp++; if (DUTY !== 3'(p / 2)) begin n_mis++; $display("FAIL square_duty[%0d]: got %0d want %0d", p, DUTY, p / 2); end
    end
  endtask

  task automatic test_en_drop();
    logic sp_e, sp_a;
    int   c;
    do_reset();
    for (int i = 0; i < 15; i++) strobe(sp_e, sp_a);
    n_cmp++; if (STATE !== S_DN || DUTY !== 3'd2) begin n_mis++; $display("FAIL endrop_pre: got state %0d duty %0d want %0d/2", STATE, DUTY, S_DN); end
    TICK_IN = 1'b1; EN = 1'b0;
    clk1();
    n_cmp++; if (STATE !== S_IDLE) begin n_mis++; $display("FAIL endrop_state: got %0d want %0d", STATE, S_IDLE); end
    n_cmp++; if (DUTY !== 3'd0) begin n_mis++; $display("FAIL endrop_duty: got %0d want 0", DUTY); end
    TICK_IN = 1'b0;
    clk1();
    n_cmp++; if (LED0 !== 1'b0) begin n_mis++; $display("FAIL endrop_led: got %b want 0", LED0); end
    count_led(8, c);
    n_cmp++; if (c != 0) begin n_mis++; $display("FAIL endrop_led_idle: got %0d highs want 0", c); end
    EN = 1'b1;
    clk1();
    n_cmp++; if (STATE !== S_UP || DUTY !== 3'd0) begin n_mis++; $display("FAIL reen_state: got state %0d duty %0d want %0d/0", STATE, DUTY, S_UP); end
    strobe(sp_e, sp_a);
    n_cmp++; if (DUTY !== 3'd0) begin n_mis++; $display("FAIL reen_tick1: got %0d want 0", DUTY); end
    strobe(sp_e, sp_a);
    n_cmp++; if (DUTY !== 3'd1 || sp_e !== 1'b1) begin n_mis++; $display("FAIL reen_tick2: got duty %0d step %b want 1/1", DUTY, sp_e); end
  endtask

  task automatic test_reset_hold();
    logic sp_e, sp_a;
    do_reset();
    for (int i = 0; i < 9; i++) strobe(sp_e, sp_a);
    n_cmp++; if (STATE !== S_HH) begin n_mis++; $display("FAIL rsthold_pre: got %0d want %0d", STATE, S_HH); end
    RST_N = 1'b0; TICK_IN = 1'b1;
    clk1();
    n_cmp++; if (STATE !== S_IDLE || DUTY !== 3'd0) begin n_mis++; $display("FAIL rsthold_state: got state %0d duty %0d want 0/0", STATE, DUTY); end
    n_cmp++; if (STEP_P !== 1'b0 || LED0 !== 1'b0) begin n_mis++; $display("FAIL rsthold_outs: got step %b led %b want 0/0", STEP_P, LED0); end
    RST_N = 1'b1; TICK_IN = 1'b0;
    clk1();
    n_cmp++; if (STEP_P !== 1'b0 || STATE !== S_UP) begin n_mis++; $display("FAIL rsthold_release: got step %b state %0d want 0/%0d", STEP_P, STATE, S_UP); end
    strobe(sp_e, sp_a);
    n_cmp++; if (DUTY !== 3'd0 || sp_e !== 1'b0) begin n_mis++; $display("FAIL rsthold_tick1: got duty %0d step %b want 0/0", DUTY, sp_e); end
    strobe(sp_e, sp_a);
    n_cmp++; if (DUTY !== 3'd1) begin n_mis++; $display("FAIL rsthold_tick2: got %0d want 1", DUTY); end
  endtask

  initial begin
    RST_N = 1'b0; TICK_IN = 1'b0; EN = 1'b0;
    test_reset();
    test_full_ramp();
    test_square_wave();
    test_en_drop();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
